mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: scalar element width.
REQ-002 Parameter VECTOR_SIZE, default 6: elements per memory word; word width W = DATA_WIDTH*VECTOR_SIZE.
REQ-003 Parameter ADDRESS_WIDTH, default 16: memory word address width.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cpuReq / cpuWrite  in  1 / 1  memory-stage access request; 1 = write, 0 = read.
REQ-007 cpuAddress / cpuWriteData  in  ADDRESS_WIDTH / W  CPU access address and store data.
REQ-008 cpuReadData / cpuStall  out  W / 1  CPU load data; pipeline stall request.
REQ-009 hostReq / hostWrite  in  1 / 1  host burst request; 1 = load memory, 0 = read back.
REQ-010 hostBaseAddress / hostLength  in  ADDRESS_WIDTH / 4  burst start address; beat count 0..8.
REQ-011 hostDataValid / hostWriteData  in  1 / W  host write beat handshake and data.
REQ-012 hostDataReady / hostReadValid / hostReadData  out  1 / 1 / W  write-beat accept; read beat strobe and data.
REQ-013 hostDone / busy  out  1 / 1  one-cycle burst-complete pulse; arbiter not IDLE.
REQ-014 memWriteEnable / memAddress / memWriteData  out  1 / ADDRESS_WIDTH / W  shared single-port memory controls.
REQ-015 memReadData  in  W  combinational read data for memAddress.

Function
REQ-016 The FSM SHALL have states IDLE, HOST_BURST and DONE.
REQ-017 In IDLE with cpuReq=1, the CPU SHALL be served the same cycle: memAddress=cpuAddress, memWriteEnable=cpuWrite, memWriteData=cpuWriteData, cpuReadData=memReadData, cpuStall=0.
REQ-018 In IDLE with hostReq=1, the FSM SHALL enter HOST_BURST next cycle, latching base, length and direction, when cpuReq=0 or the starvation count equals 4.
REQ-019 The starvation count SHALL increment on each IDLE CPU grant while hostReq=1, SHALL saturate at 4, and SHALL clear on burst entry or when hostReq=0.
REQ-020 When starvation forces a burst with cpuReq=1, the CPU SHALL be stalled that cycle (cpuStall=1, memWriteEnable=0).
REQ-021 In HOST_BURST, cpuStall SHALL equal cpuReq and all CPU accesses SHALL be blocked.
REQ-022 Write burst: hostDataReady=1; a beat completes when hostDataValid=1, driving memWriteEnable=1, memAddress=base+beat, memWriteData=hostWriteData.
REQ-023 Read burst: one beat per cycle with no backpressure; hostReadValid=1, memAddress=base+beat, hostReadData=memReadData, memWriteEnable=0.
REQ-024 Beat addresses SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-025 After the final beat (beat = latched length-1) the FSM SHALL enter DONE; in DONE, hostDone=1 for exactly one cycle, then return to IDLE.
REQ-026 hostLength=0 SHALL go IDLE->DONE with no memory access; values above 8 SHALL be clamped to 8.
REQ-027 From DONE the FSM SHALL return to IDLE and SHALL NOT grant the host again until hostReq has been low for at least one cycle.
REQ-028 Outside active beats, memWriteEnable=0, hostDataReady=0, hostReadValid=0.
REQ-029 hostBaseAddress, hostLength and hostWrite changes during a burst SHALL be ignored.

Reset
REQ-030 On reset low: state=IDLE, beat and starvation counters=0, all outputs 0, memAddress=0.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately without a hostDone pulse; the remaining beats SHALL NOT be written.

Structure
REQ-032 A shared package SHALL hold the state enum, MAX_BURST=8, STARVE_LIMIT=4 and HOST_LEN_WIDTH=4.
REQ-033 The beat counter and address generator SHALL be one sub-module, burst_counter (load, increment, last-beat flag).

Verification
REQ-034 CPU-only: cpuReq=1, cpuWrite=1, address 0x0010, data 0x...AB; then a read of 0x0010 -> same-cycle cpuReadData 0x...AB, cpuStall=0 throughout.
REQ-035 Host write burst: base 0x00FE, length 4, valid every cycle -> writes to 0x00FE, 0x00FF, 0x0100, 0x0101; hostDone pulse one cycle after the fourth beat.
REQ-036 Wraparound read: base 0xFFFF, length 2 -> beats read addresses 0xFFFF and 0x0000 on consecutive cycles, hostReadValid=1 for exactly 2 cycles.
REQ-037 Starvation: cpuReq and hostReq held high -> 4 CPU grants, then a burst starts; cpuStall=1 for the burst duration plus the entry cycle.
REQ-038 Reset low after beat 2 of 5 in a write burst -> no further memWriteEnable, no hostDone, IDLE after release.
REQ-039 hostLength=0 -> no memWriteEnable, hostDone pulses 1 cycle after the grant; hostLength=12 -> exactly 8 beats.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: the FSM state type, burst and
// starvation limits, and the host burst-length clamp.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOST_BURST = 2'd1,
    DONE       = 2'd2
  } arb_state_e;

  localparam int MAX_BURST      = 8;
  localparam int STARVE_LIMIT   = 4;
  localparam int HOST_LEN_WIDTH = 4;
  localparam int STARVE_WIDTH   = 3;

  // Requested beat counts above MAX_BURST are served as MAX_BURST beats.
  function automatic logic [HOST_LEN_WIDTH-1:0] clamp_length(
    input logic [HOST_LEN_WIDTH-1:0] len
  );
    if (len > HOST_LEN_WIDTH'(MAX_BURST)) begin
      clamp_length = HOST_LEN_WIDTH'(MAX_BURST);
    end else begin
      clamp_length = len;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU memory stage, the host burst port, the shared
// single-port memory and the arbiter.
//   slave  : arbiter view (takes CPU/host requests, drives memory controls)
//   master : environment view (CPU, host and memory model)
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int VECTOR_SIZE   = 6,
  parameter int ADDRESS_WIDTH = 16
) ();

  localparam int W = DATA_WIDTH * VECTOR_SIZE;

  // CPU memory-stage port
  logic                      cpuReq;
  logic                      cpuWrite;
  logic [ADDRESS_WIDTH-1:0]  cpuAddress;
  logic [W-1:0]              cpuWriteData;
  logic [W-1:0]              cpuReadData;
  logic                      cpuStall;

  // Host burst port
  logic                      hostReq;
  logic                      hostWrite;
  logic [ADDRESS_WIDTH-1:0]  hostBaseAddress;
  logic [HOST_LEN_WIDTH-1:0] hostLength;
  logic                      hostDataValid;
  logic [W-1:0]              hostWriteData;
  logic                      hostDataReady;
  logic                      hostReadValid;
  logic [W-1:0]              hostReadData;
  logic                      hostDone;
  logic                      busy;

  // Shared memory port
  logic                      memWriteEnable;
  logic [ADDRESS_WIDTH-1:0]  memAddress;
  logic [W-1:0]              memWriteData;
  logic [W-1:0]              memReadData;

  modport slave (
    input  cpuReq, cpuWrite, cpuAddress, cpuWriteData,
    output cpuReadData, cpuStall,
    input  hostReq, hostWrite, hostBaseAddress, hostLength, hostDataValid, hostWriteData,
    output hostDataReady, hostReadValid, hostReadData, hostDone, busy,
    output memWriteEnable, memAddress, memWriteData,
    input  memReadData
  );

  modport master (
    output cpuReq, cpuWrite, cpuAddress, cpuWriteData,
    input  cpuReadData, cpuStall,
    output hostReq, hostWrite, hostBaseAddress, hostLength, hostDataValid, hostWriteData,
    input  hostDataReady, hostReadValid, hostReadData, hostDone, busy,
    input  memWriteEnable, memAddress, memWriteData,
    output memReadData
  );

endinterface

// File: rtl/mem_arbiter_burst_counter.sv
// Host burst beat counter and address generator.
//   load      : capture base address and (already clamped) length, beat = 0
//   incr      : advance to the next beat
//   beat_addr : base + beat, wrapping modulo 2^ADDRESS_WIDTH
//   last_beat : current beat is the final one of the latched length
module burst_counter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [ADDRESS_WIDTH-1:0]  base_addr,
  input  logic [HOST_LEN_WIDTH-1:0] length,
  input  logic                      incr,
  output logic [ADDRESS_WIDTH-1:0]  beat_addr,
  output logic                      last_beat
);

  logic [ADDRESS_WIDTH-1:0]  base_r;
  logic [HOST_LEN_WIDTH-1:0] len_r;
  logic [HOST_LEN_WIDTH-1:0] beat_r;

  // Burst parameters are captured once so host-side changes mid-burst are ignored
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base_r <= {ADDRESS_WIDTH{1'b0}};
      len_r  <= {HOST_LEN_WIDTH{1'b0}};
      beat_r <= {HOST_LEN_WIDTH{1'b0}};
    end else if (load) begin
      base_r <= base_addr;
      len_r  <= length;
      beat_r <= {HOST_LEN_WIDTH{1'b0}};
    end else if (incr) begin
      base_r <= base_r;
      len_r  <= len_r;
      beat_r <= beat_r + HOST_LEN_WIDTH'(1'b1);
    end else begin
      base_r <= base_r;
      len_r  <= len_r;
      beat_r <= beat_r;
    end
  end

  // Unsigned addition truncates to the address width, giving the wraparound.
  assign beat_addr = base_r + ADDRESS_WIDTH'(beat_r);
  assign last_beat = (beat_r == (len_r - HOST_LEN_WIDTH'(1'b1)));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for one single-port memory shared by the CPU memory stage and a
// host burst engine. The CPU is served combinationally while IDLE; the host
// takes the memory for a whole burst (up to 8 beats), and a starvation
// counter forces the host in after 4 consecutive CPU wins.
// Ports: clock, reset (async, active low), bus (mem_arbiter_if.slave).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int VECTOR_SIZE   = 6,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int W = DATA_WIDTH * VECTOR_SIZE;

  arb_state_e                state_r;
  logic [STARVE_WIDTH-1:0]   starve_r;
  logic                      write_r;
  logic                      armed_r;
  logic                      host_done_r;
  logic                      busy_r;

  logic                      starved_s;
  logic                      host_win_s;
  logic                      grant_s;
  logic                      incr_s;
  logic [HOST_LEN_WIDTH-1:0] len_clamped_s;
  logic [ADDRESS_WIDTH-1:0]  beat_addr_s;
  logic                      last_beat_s;
  logic                      cpu_stall_s;
  logic [W-1:0]              cpu_rdata_s;
  logic                      mem_we_s;
  logic [ADDRESS_WIDTH-1:0]  mem_addr_s;
  logic [W-1:0]              mem_wdata_s;
  logic                      host_ready_s;
  logic                      host_rvalid_s;
  logic [W-1:0]              host_rdata_s;

  assign len_clamped_s = clamp_length(bus.hostLength);
  assign starved_s     = (starve_r == STARVE_WIDTH'(STARVE_LIMIT));
  // armed_r blocks an immediate re-grant to a host that keeps hostReq high.
  assign host_win_s    = bus.hostReq & armed_r & (~bus.cpuReq | starved_s);

  burst_counter #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_burst_counter (
    .clock     (clock),
    .reset     (reset),
    .load      (grant_s),
    .base_addr (bus.hostBaseAddress),
    .length    (len_clamped_s),
    .incr      (incr_s),
    .beat_addr (beat_addr_s),
    .last_beat (last_beat_s)
  );

  // Memory port steering: CPU pass-through in IDLE, one host beat per accepted cycle in HOST_BURST
  always_comb begin
    grant_s       = 1'b0;
    incr_s        = 1'b0;
    cpu_stall_s   = 1'b0;
    cpu_rdata_s   = {W{1'b0}};
    mem_we_s      = 1'b0;
    mem_addr_s    = {ADDRESS_WIDTH{1'b0}};
    mem_wdata_s   = {W{1'b0}};
    host_ready_s  = 1'b0;
    host_rvalid_s = 1'b0;
    host_rdata_s  = {W{1'b0}};
    if (!reset) begin
      // Everything held at zero while reset is asserted, including the CPU path.
      grant_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (host_win_s) begin
            // Entry cycle: a CPU request that lost to starvation is stalled.
            grant_s     = 1'b1;
            cpu_stall_s = bus.cpuReq;
          end else if (bus.cpuReq) begin
            mem_addr_s  = bus.cpuAddress;
            mem_we_s    = bus.cpuWrite;
            mem_wdata_s = bus.cpuWriteData;
            cpu_rdata_s = bus.memReadData;
          end else begin
            cpu_stall_s = 1'b0;
          end
        end
        HOST_BURST: begin
          cpu_stall_s = bus.cpuReq;
          if (write_r) begin
            host_ready_s = 1'b1;
            if (bus.hostDataValid) begin
              incr_s      = 1'b1;
              mem_we_s    = 1'b1;
              mem_addr_s  = beat_addr_s;
              mem_wdata_s = bus.hostWriteData;
            end else begin
              incr_s = 1'b0;
            end
          end else begin
            // Reads never back-pressure: one beat every cycle.
            incr_s        = 1'b1;
            host_rvalid_s = 1'b1;
            mem_addr_s    = beat_addr_s;
            host_rdata_s  = bus.memReadData;
          end
        end
        DONE: begin
          cpu_stall_s = bus.cpuReq;
        end
        default: begin
          cpu_stall_s = bus.cpuReq;
        end
      endcase
    end
  end

  // Arbiter FSM with starvation tracking, host re-arm and registered status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      starve_r    <= {STARVE_WIDTH{1'b0}};
      write_r     <= 1'b0;
      armed_r     <= 1'b1;
      host_done_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            write_r  <= bus.hostWrite;
            starve_r <= {STARVE_WIDTH{1'b0}};
            armed_r  <= armed_r;
            busy_r   <= 1'b1;
            if (len_clamped_s == {HOST_LEN_WIDTH{1'b0}}) begin
              state_r     <= DONE;
              host_done_r <= 1'b1;
            end else begin
              state_r     <= HOST_BURST;
              host_done_r <= 1'b0;
            end
          end else begin
            state_r     <= IDLE;
            write_r     <= write_r;
            busy_r      <= 1'b0;
            host_done_r <= 1'b0;
            if (!bus.hostReq) begin
              starve_r <= {STARVE_WIDTH{1'b0}};
              armed_r  <= 1'b1;
            end else if (bus.cpuReq && !starved_s) begin
              starve_r <= starve_r + STARVE_WIDTH'(1'b1);
              armed_r  <= armed_r;
            end else begin
              starve_r <= starve_r;
              armed_r  <= armed_r;
            end
          end
        end
        HOST_BURST: begin
          write_r  <= write_r;
          starve_r <= starve_r;
          armed_r  <= armed_r;
          busy_r   <= 1'b1;
          if (incr_s && last_beat_s) begin
            state_r     <= DONE;
            host_done_r <= 1'b1;
          end else begin
            state_r     <= HOST_BURST;
            host_done_r <= 1'b0;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          write_r     <= write_r;
          starve_r    <= {STARVE_WIDTH{1'b0}};
          // A low hostReq during DONE already counts as the required gap.
          armed_r     <= ~bus.hostReq;
          host_done_r <= 1'b0;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          write_r     <= 1'b0;
          starve_r    <= {STARVE_WIDTH{1'b0}};
          armed_r     <= 1'b1;
          host_done_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpuStall       = cpu_stall_s;
  assign bus.cpuReadData    = cpu_rdata_s;
  assign bus.memWriteEnable = mem_we_s;
  assign bus.memAddress     = mem_addr_s;
  assign bus.memWriteData   = mem_wdata_s;
  assign bus.hostDataReady  = host_ready_s;
  assign bus.hostReadValid  = host_rvalid_s;
  assign bus.hostReadData   = host_rdata_s;
  assign bus.hostDone       = host_done_r;
  assign bus.busy           = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural memory, a reference memory image
// kept from the arbitration rules, and one task per scenario.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int VS = 6;
  localparam int AW = 16;
  localparam int W  = DW * VS;

  logic clock = 1'b0;
  logic reset = 1'b0;

  mem_arbiter_if #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ADDRESS_WIDTH(AW)) bus ();

  mem_arbiter #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ADDRESS_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Shared memory seen by the DUT (zero-initialised)
  bit [W-1:0] mem [0:65535];
  assign bus.memReadData = mem[bus.memAddress];
  always @(posedge clock) begin
    if (bus.memWriteEnable === 1'b1) mem[bus.memAddress] <= bus.memWriteData;
  end

  // Reference image: what the memory must contain per the arbitration rules
  logic [W-1:0] ref_mem [int];
  int checks   = 0;
  int failures = 0;

  function automatic logic [W-1:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return {W{1'b0}};
  endfunction

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic drive_idle();
    bus.cpuReq = 1'b0; bus.cpuWrite = 1'b0; bus.cpuAddress = '0; bus.cpuWriteData = '0;
    bus.hostReq = 1'b0; bus.hostWrite = 1'b0; bus.hostBaseAddress = '0; bus.hostLength = '0;
    bus.hostDataValid = 1'b0; bus.hostWriteData = '0;
  endtask

  // One CPU access while the host is not requesting
  task automatic cpu_op(input bit wr, input int addr, input logic [W-1:0] d, input string tag);
    @(negedge clock);
    bus.hostReq = 1'b0; bus.cpuReq = 1'b1; bus.cpuWrite = wr;
    bus.cpuAddress = addr[AW-1:0]; bus.cpuWriteData = d;
    #1;
    checks++; if (bus.cpuStall !== 1'b0) begin failures++; $display("FAIL %s cpu_stall got=%0h exp=0", tag, bus.cpuStall); end
    checks++; if (bus.memAddress !== addr[AW-1:0]) begin failures++; $display("FAIL %s mem_addr got=%0h exp=%0h", tag, bus.memAddress, addr[AW-1:0]); end
    checks++; if (bus.memWriteEnable !== wr) begin failures++; $display("FAIL %s mem_we got=%0h exp=%0h", tag, bus.memWriteEnable, wr); end
    if (wr) begin
      checks++; if (bus.memWriteData !== d) begin failures++; $display("FAIL %s mem_wdata got=%0h exp=%0h", tag, bus.memWriteData, d); end
      ref_mem[addr] = d;
    end else begin
      checks++; if (bus.cpuReadData !== ref_rd(addr)) begin failures++; $display("FAIL %s cpu_rdata got=%0h exp=%0h", tag, bus.cpuReadData, ref_rd(addr)); end
    end
  endtask

  // Complete host burst with CPU idle; host-side fields are scrambled during the burst
  task automatic run_burst(input bit wr, input int base, input int len, input bit gaps, input string tag);
    int eff; int beats; int cycles; bit v; logic [W-1:0] d; logic [AW-1:0] ea;
    eff = (len > 8) ? 8 : len; beats = 0; cycles = 0;
    @(negedge clock);
    bus.cpuReq = 1'b0; bus.hostReq = 1'b1; bus.hostWrite = wr; bus.hostBaseAddress = base[AW-1:0];
    bus.hostLength = len[3:0]; bus.hostDataValid = 1'b1; bus.hostWriteData = rnd_word();
    #1;
    checks++; if (bus.memWriteEnable !== 1'b0) begin failures++; $display("FAIL %s grant_we got=%0h exp=0", tag, bus.memWriteEnable); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s grant_busy got=%0h exp=0", tag, bus.busy); end
    while (beats < eff && cycles < 64) begin
      @(negedge clock); cycles++;
      bus.hostBaseAddress = AW'($urandom); bus.hostLength = 4'($urandom_range(0, 15));
      bus.hostWrite = 1'($urandom_range(0, 1));
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1; d = rnd_word();
      bus.hostDataValid = v; bus.hostWriteData = d;
      ea = AW'((base + beats) % 65536);
      #1;
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL %s beat_busy got=%0h exp=1", tag, bus.busy); end
      checks++; if (bus.hostDone !== 1'b0) begin failures++; $display("FAIL %s beat_done got=%0h exp=0", tag, bus.hostDone); end
      if (wr) begin
        checks++; if (bus.hostDataReady !== 1'b1) begin failures++; $display("FAIL %s wr_ready got=%0h exp=1", tag, bus.hostDataReady); end
        checks++; if (bus.memWriteEnable !== v) begin failures++; $display("FAIL %s wr_we got=%0h exp=%0h", tag, bus.memWriteEnable, v); end
        if (v) begin
          checks++; if (bus.memAddress !== ea) begin failures++; $display("FAIL %s wr_addr got=%0h exp=%0h", tag, bus.memAddress, ea); end
          checks++; if (bus.memWriteData !== d) begin failures++; $display("FAIL %s wr_data got=%0h exp=%0h", tag, bus.memWriteData, d); end
          ref_mem[int'(ea)] = d;
          beats++;
        end
      end else begin
        checks++; if (bus.hostReadValid !== 1'b1) begin failures++; $display("FAIL %s rd_valid got=%0h exp=1", tag, bus.hostReadValid); end
        checks++; if (bus.memWriteEnable !== 1'b0) begin failures++; $display("FAIL %s rd_we got=%0h exp=0", tag, bus.memWriteEnable); end
        checks++; if (bus.memAddress !== ea) begin failures++; $display("FAIL %s rd_addr got=%0h exp=%0h", tag, bus.memAddress, ea); end
        checks++; if (bus.hostReadData !== ref_rd(int'(ea))) begin failures++; $display("FAIL %s rd_data got=%0h exp=%0h", tag, bus.hostReadData, ref_rd(int'(ea))); end
        beats++;
      end
    end
    checks++; if (beats != eff) begin failures++; $display("FAIL %s beat_timeout got=%0d exp=%0d", tag, beats, eff); end
    @(negedge clock);
    bus.hostReq = 1'b0; bus.hostDataValid = 1'b1;
    #1;
    checks++; if (bus.hostDone !== 1'b1) begin failures++; $display("FAIL %s done_pulse got=%0h exp=1", tag, bus.hostDone); end
    checks++; if (bus.memWriteEnable !== 1'b0) begin failures++; $display("FAIL %s done_we got=%0h exp=0", tag, bus.memWriteEnable); end
    checks++; if (bus.hostDataReady !== 1'b0) begin failures++; $display("FAIL %s done_ready got=%0h exp=0", tag, bus.hostDataReady); end
    checks++; if (bus.hostReadValid !== 1'b0) begin failures++; $display("FAIL %s done_rvalid got=%0h exp=0", tag, bus.hostReadValid); end
    @(negedge clock);
    bus.hostDataValid = 1'b0;
    #1;
    checks++; if (bus.hostDone !== 1'b0) begin failures++; $display("FAIL %s done_single got=%0h exp=0", tag, bus.hostDone); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s idle_busy got=%0h exp=0", tag, bus.busy); end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    bus.cpuReq = 1'b1; bus.cpuWrite = 1'b1; bus.cpuAddress = 16'h1234; bus.hostReq = 1'b1; bus.hostDataValid = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (bus.cpuStall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", bus.cpuStall); end
    checks++; if (bus.memWriteEnable !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", bus.memWriteEnable); end
    checks++; if (bus.memAddress !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%0h exp=0", bus.memAddress); end
    checks++; if (bus.cpuReadData !== {W{1'b0}}) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", bus.cpuReadData); end
    checks++; if (bus.hostDone !== 1'b0) begin failures++; $display("FAIL reset_done got=%0h exp=0", bus.hostDone); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
    checks++; if (bus.hostDataReady !== 1'b0 || bus.hostReadValid !== 1'b0) begin failures++; $display("FAIL reset_host got=%0h%0h exp=00", bus.hostDataReady, bus.hostReadValid); end
    @(negedge clock);
    drive_idle();
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%0h exp=0", bus.busy); end
  endtask

  task automatic test_cpu_access();
    logic [W-1:0] d;
    d = rnd_word(); d[7:0] = 8'hAB;
    cpu_op(1'b1, 32'h0010, d, "cpu_wr10");
    cpu_op(1'b0, 32'h0010, rnd_word(), "cpu_rd10");
    checks++; if (bus.cpuReadData[7:0] !== 8'hAB) begin failures++; $display("FAIL cpu_rd10_ab got=%0h exp=ab", bus.cpuReadData[7:0]); end
    for (int i = 0; i < 8; i++) cpu_op(1'b1, 32'h20 + i, rnd_word(), "cpu_fill");
    for (int i = 0; i < 16; i++) cpu_op(1'($urandom_range(0, 1)), 32'h20 + $urandom_range(0, 7), rnd_word(), "cpu_rand");
  endtask

  task automatic test_host_write();
    run_burst(1'b1, 32'h00FE, 4, 1'b0, "hw_fe");
    for (int i = 0; i < 4; i++) cpu_op(1'b0, 32'h00FE + i, rnd_word(), "hw_readback");
  endtask

  task automatic test_wrap_read();
    run_burst(1'b1, 32'hFFFF, 2, 1'b1, "wrap_wr");
    run_burst(1'b0, 32'hFFFF, 2, 1'b0, "wrap_rd");
  endtask

  task automatic test_starvation();
    int base; int len; int a; logic [W-1:0] d; logic [AW-1:0] ea;
    base = $urandom_range(0, 65535); len = $urandom_range(1, 8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bus.hostReq = 1'b1; bus.hostWrite = 1'b0; bus.hostBaseAddress = base[AW-1:0]; bus.hostLength = len[3:0];
      a = 32'h300 + i; d = rnd_word();
      bus.cpuReq = 1'b1; bus.cpuWrite = 1'b1; bus.cpuAddress = a[AW-1:0]; bus.cpuWriteData = d;
      #1;
      checks++; if (bus.cpuStall !== 1'b0) begin failures++; $display("FAIL starve_grant%0d_stall got=%0h exp=0", i, bus.cpuStall); end
      checks++; if (bus.memWriteEnable !== 1'b1 || bus.memAddress !== a[AW-1:0]) begin failures++; $display("FAIL starve_grant%0d_mem got=%0h/%0h exp=1/%0h", i, bus.memWriteEnable, bus.memAddress, a[AW-1:0]); end
      ref_mem[a] = d;
    end
    @(negedge clock);
    bus.cpuAddress = 16'h03FF; bus.cpuWriteData = rnd_word();
    #1;
    checks++; if (bus.cpuStall !== 1'b1) begin failures++; $display("FAIL starve_entry_stall got=%0h exp=1", bus.cpuStall); end
    checks++; if (bus.memWriteEnable !== 1'b0) begin failures++; $display("FAIL starve_entry_we got=%0h exp=0", bus.memWriteEnable); end
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      bus.hostBaseAddress = AW'($urandom); ea = AW'((base + i) % 65536);
      #1;
      checks++; if (bus.cpuStall !== 1'b1) begin failures++; $display("FAIL starve_beat_stall got=%0h exp=1", bus.cpuStall); end
      checks++; if (bus.hostReadValid !== 1'b1 || bus.memWriteEnable !== 1'b0) begin failures++; $display("FAIL starve_beat_ctl got=%0h/%0h exp=1/0", bus.hostReadValid, bus.memWriteEnable); end
      checks++; if (bus.memAddress !== ea) begin failures++; $display("FAIL starve_beat_addr got=%0h exp=%0h", bus.memAddress, ea); end
      checks++; if (bus.hostReadData !== ref_rd(int'(ea))) begin failures++; $display("FAIL starve_beat_data got=%0h exp=%0h", bus.hostReadData, ref_rd(int'(ea))); end
    end
    @(negedge clock);
    #1;
    checks++; if (bus.hostDone !== 1'b1 || bus.cpuStall !== 1'b1) begin failures++; $display("FAIL starve_done got=%0h/%0h exp=1/1", bus.hostDone, bus.cpuStall); end
    // hostReq held high: no re-grant, CPU served even past the starvation limit
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      a = 32'h310 + i; d = rnd_word(); bus.cpuAddress = a[AW-1:0]; bus.cpuWriteData = d;
      #1;
      checks++; if (bus.cpuStall !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL starve_norearm%0d got=%0h/%0h exp=0/0", i, bus.cpuStall, bus.busy); end
      checks++; if (bus.memWriteEnable !== 1'b1 || bus.memAddress !== a[AW-1:0]) begin failures++; $display("FAIL starve_norearm%0d_mem got=%0h/%0h exp=1/%0h", i, bus.memWriteEnable, bus.memAddress, a[AW-1:0]); end
      ref_mem[a] = d;
    end
    @(negedge clock);
    bus.hostReq = 1'b0; bus.cpuReq = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL starve_exit_busy got=%0h exp=0", bus.busy); end
    for (int i = 0; i < 4; i++) cpu_op(1'b0, 32'h300 + i, rnd_word(), "starve_readback");
  endtask

  task automatic test_zero_and_clamp();
    int base;
    base = $urandom_range(0, 65535);
    run_burst(1'b1, base, 0, 1'b0, "len0");
    run_burst(1'b1, base, 12, 1'b1, "len12_wr");
    run_burst(1'b0, base, 12, 1'b0, "len12_rd");
    run_burst(1'b0, base, 15, 1'b0, "len15_rd");
  endtask

  task automatic test_reset_midburst();
    int base; logic [W-1:0] d; logic [AW-1:0] ea;
    base = $urandom_range(0, 65535);
    @(negedge clock);
    bus.cpuReq = 1'b0; bus.hostReq = 1'b1; bus.hostWrite = 1'b1; bus.hostBaseAddress = base[AW-1:0];
    bus.hostLength = 4'd5; bus.hostDataValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      d = rnd_word(); bus.hostDataValid = 1'b1; bus.hostWriteData = d; ea = AW'((base + i) % 65536);
      #1;
      checks++; if (bus.memWriteEnable !== 1'b1 || bus.memAddress !== ea) begin failures++; $display("FAIL rstmid_beat%0d got=%0h/%0h exp=1/%0h", i, bus.memWriteEnable, bus.memAddress, ea); end
      ref_mem[int'(ea)] = d;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      reset = 1'b0; bus.hostWriteData = rnd_word();
      #1;
      checks++; if (bus.memWriteEnable !== 1'b0) begin failures++; $display("FAIL rstmid_we got=%0h exp=0", bus.memWriteEnable); end
      checks++; if (bus.hostDone !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_status got=%0h/%0h exp=0/0", bus.hostDone, bus.busy); end
    end
    @(negedge clock);
    reset = 1'b1; bus.hostReq = 1'b0; bus.hostDataValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.hostDone !== 1'b0 || bus.busy !== 1'b0 || bus.memWriteEnable !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%0h/%0h/%0h exp=0/0/0", bus.hostDone, bus.busy, bus.memWriteEnable); end
      @(negedge clock);
    end
    for (int i = 2; i < 5; i++) begin
      ea = AW'((base + i) % 65536);
      checks++; if (mem[ea] !== ref_rd(int'(ea))) begin failures++; $display("FAIL rstmid_unwritten got=%0h exp=%0h", mem[ea], ref_rd(int'(ea))); end
    end
  endtask

  task automatic test_random();
    int base;
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < $urandom_range(0, 3); k++)
        cpu_op(1'($urandom_range(0, 1)), (32'hFFF8 + $urandom_range(0, 15)) % 65536, rnd_word(), "rand_cpu");
      base = (32'hFFF8 + $urandom_range(0, 15)) % 65536;
      run_burst(1'($urandom_range(0, 1)), base, $urandom_range(0, 15), 1'b1, "rand_burst");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_access();
    test_host_write();
    test_wrap_read();
    test_starvation();
    test_zero_and_clamp();
    test_reset_midburst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
